// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder: Wishbone B4 classic single-master address decoder.
//
// This block sits directly behind the CPU bus master. It decodes each
// request to one of three slaves (RAM, UART, timer), forwards the cycle,
// and returns a registered ACK with the read data. An unmapped access or
// a slave that never answers still ends with a normal ACK. In that case
// the read data is poisoned and a sticky error flag is set.
//
// Ports:
//   CLK_I, RST_I                      clock (rising edge), async active-low reset
//   ADR_I/DAT_I/SEL_I/WE_I/CYC_I/STB_I master request
//   DAT_O/ACK_O                       read data and termination to master
//   ERR_O/ERR_ADR_O/ERR_CLR_I         sticky error flag, first faulting address, clear
//   S_ADR_O/S_DAT_O/S_SEL_O/S_WE_O    shared slave request bus
//   S_CYC_O/S_STB_O                   per-slave one-hot cycle/strobe
//   S_ACK_I/S_DAT_I                   per-slave ack and read data (slave n at [32n+31:32n])
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for CYC&STB; ignores the master for one cycle after RESP
// ACTIVE | slave strobed, waiting for its ACK or for the timeout
// RESP   | ACK_O high for this single cycle, DAT_O valid
module wb_addr_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_FF00,
  parameter logic [31:0] S2_BASE = 32'h0001_0100,
  parameter logic [31:0] S2_MASK = 32'hFFFF_FF00,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] POISON  = 32'hDEAD_BEEF
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  input  logic        WE_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] ERR_ADR_O,
  input  logic        ERR_CLR_I,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  output logic [3:0]  S_SEL_O,
  output logic        S_WE_O,
  output logic [2:0]  S_CYC_O,
  output logic [2:0]  S_STB_O,
  input  logic [2:0]  S_ACK_I,
  input  logic [95:0] S_DAT_I
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        hold_off;
  logic        req_we;
  logic        req;
  logic [2:0]  hit;
  logic        hit_any;
  logic        ack_hit;
  logic        tmo;
  logic        err_set;
  logic [31:0] ack_dat;

  // Priority decode: the lowest slave index wins on overlapping windows.
  always_comb begin
    hit = 3'b000;
    if ((ADR_I & S0_MASK) == S0_BASE)      hit = 3'b001;
    else if ((ADR_I & S1_MASK) == S1_BASE) hit = 3'b010;
    else if ((ADR_I & S2_MASK) == S2_BASE) hit = 3'b100;
  end

  assign hit_any = |hit;

  // hold_off is high only in the IDLE cycle right after RESP. It masks the
  // master's request in that cycle, which keeps one idle cycle between
  // transactions even if CYC_I is still high.
  assign req = CYC_I & STB_I & ~hold_off;

  // Only an ACK from the slave being strobed counts.
  assign ack_hit = |(S_ACK_I & S_STB_O);

  assign cnt_nxt = cnt + 8'd1;
  assign tmo     = (cnt_nxt == TIMEOUT_C);

  always_comb begin
    ack_dat = S_DAT_I[31:0];
    if (S_STB_O[1])      ack_dat = S_DAT_I[63:32];
    else if (S_STB_O[2]) ack_dat = S_DAT_I[95:64];
  end

  assign err_set = ((state == ST_IDLE) & req & ~hit_any) |
                   ((state == ST_ACTIVE) & CYC_I & ~ack_hit & tmo);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      hold_off <= 1'b0;
      req_we   <= 1'b0;
      DAT_O    <= 32'd0;
      ACK_O    <= 1'b0;
      S_ADR_O  <= 32'd0;
      S_DAT_O  <= 32'd0;
      S_SEL_O  <= 4'd0;
      S_WE_O   <= 1'b0;
      S_CYC_O  <= 3'b000;
      S_STB_O  <= 3'b000;
    end else begin
      ACK_O <= 1'b0;
      case (state)
        ST_IDLE: begin
          hold_off <= 1'b0;
          if (req) begin
            S_ADR_O <= ADR_I;
            S_DAT_O <= DAT_I;
            S_SEL_O <= SEL_I;
            // Do not show a write enable on the bus when no strobe follows.
            S_WE_O  <= WE_I & hit_any;
            req_we  <= WE_I;
            if (hit_any) begin
              S_CYC_O <= hit;
              S_STB_O <= hit;
              cnt     <= 8'd0;
              state   <= ST_ACTIVE;
            end else begin
              DAT_O <= WE_I ? 32'd0 : POISON;
              ACK_O <= 1'b1;
              state <= ST_RESP;
            end
          end
        end

        ST_ACTIVE: begin
          if (!CYC_I) begin
            S_CYC_O <= 3'b000;
            S_STB_O <= 3'b000;
            S_WE_O  <= 1'b0;
            state   <= ST_IDLE;
          end else if (ack_hit) begin
            DAT_O   <= ack_dat;
            S_CYC_O <= 3'b000;
            S_STB_O <= 3'b000;
            S_WE_O  <= 1'b0;
            ACK_O   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt_nxt;
            if (tmo) begin
              DAT_O   <= req_we ? 32'd0 : POISON;
              S_CYC_O <= 3'b000;
              S_STB_O <= 3'b000;
              S_WE_O  <= 1'b0;
              ACK_O   <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          hold_off <= 1'b1;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flag. A new error outranks a simultaneous clear. The
  // address is captured only while the flag is clear, so ERR_ADR_O keeps
  // the first fault.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ERR_O     <= 1'b0;
      ERR_ADR_O <= 32'd0;
    end else if (err_set) begin
      ERR_O <= 1'b1;
      if (!ERR_O) ERR_ADR_O <= ADR_I;
    end else if (ERR_CLR_I) begin
      ERR_O <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_addr_decoder.sv
module tb_wb_addr_decoder;

  localparam int          TMO    = 8;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] ADR_I = '0;
  logic [31:0] DAT_I = '0;
  logic [3:0]  SEL_I = '0;
  logic        WE_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        ERR_O;
  logic [31:0] ERR_ADR_O;
  logic        ERR_CLR_I = 1'b0;
  logic [31:0] S_ADR_O;
  logic [31:0] S_DAT_O;
  logic [3:0]  S_SEL_O;
  logic        S_WE_O;
  logic [2:0]  S_CYC_O;
  logic [2:0]  S_STB_O;
  logic [2:0]  S_ACK_I;
  logic [95:0] S_DAT_I;

  wb_addr_decoder #(.TIMEOUT(TMO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
    .WE_I(WE_I), .CYC_I(CYC_I), .STB_I(STB_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .ERR_O(ERR_O), .ERR_ADR_O(ERR_ADR_O), .ERR_CLR_I(ERR_CLR_I),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O), .S_WE_O(S_WE_O),
    .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_ACK_I(S_ACK_I), .S_DAT_I(S_DAT_I)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0;
  int n_fail = 0;

  // Slave models: slave n ACKs lat[n] cycles after its strobe rises
  // (0 = same cycle, 255 = never). With noise set, slaves that are not
  // strobed hold their ACK high to tempt the decoder.
  int          lat [3] = '{0, 0, 0};
  logic [31:0] sdat [3] = '{32'h1234_5678, 32'h0000_00C3, 32'hCAFE_F00D};
  logic        noise = 1'b0;
  logic [7:0]  scnt [3];

  always @(posedge CLK_I or negedge RST_I) begin
    for (int i = 0; i < 3; i++) begin
      if (!RST_I) scnt[i] <= 8'd0;
      else        scnt[i] <= S_STB_O[i] ? scnt[i] + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    S_ACK_I = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (S_STB_O[i]) S_ACK_I[i] = (lat[i] != 255) && (int'(scnt[i]) == lat[i]);
      else            S_ACK_I[i] = noise;
    end
  end

  assign S_DAT_I = {sdat[2], sdat[1], sdat[0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus-wide invariants checked every cycle out of reset.
  logic prev_ack = 1'b0;
  always @(negedge CLK_I) begin
    if (RST_I) begin
      n_chk++;
      if ($countones(S_STB_O) > 1 || S_CYC_O != S_STB_O || (prev_ack && ACK_O)) begin
        n_fail++;
        $display("FAIL bus_invariant: stb=%b cyc=%b ack=%b prev_ack=%b", S_STB_O, S_CYC_O, ACK_O, prev_ack);
      end
      prev_ack = ACK_O;
    end else begin
      prev_ack = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One master transaction; results sampled on falling edges. lat_o is
  // the cycle number of ACK_O counted from the request edge.
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, output int lat_o, output logic [31:0] dat_o,
                      output logic [2:0] stb_o, output logic we_o, output logic [3:0] sel_o,
                      output logic [31:0] sdat_o, output logic err_o, output logic [31:0] eadr_o);
    int n;
    bit done;
    lat_o = 0; dat_o = '0; stb_o = '0; we_o = 1'b0; sel_o = '0; sdat_o = '0;
    err_o = 1'b0; eadr_o = '0;
    @(negedge CLK_I);
    ADR_I = adr; DAT_I = dat; SEL_I = sel; WE_I = we; CYC_I = 1'b1; STB_I = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge CLK_I);
      n++;
      if (S_STB_O != 3'b000) begin
        stb_o  = stb_o | S_STB_O;
        we_o   = S_WE_O;
        sel_o  = S_SEL_O;
        sdat_o = S_DAT_O;
      end
      if (ACK_O) begin
        done = 1'b1; lat_o = n; dat_o = DAT_O; err_o = ERR_O; eadr_o = ERR_ADR_O;
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL xfer_budget: no ACK_O within 300 cycles for adr %h", adr);
    end
    @(negedge CLK_I);
    check("ack_single", 32'(ACK_O), 32'd0);
    check("stb_dropped", 32'(S_STB_O), 32'd0);
    check("we_dropped", 32'(S_WE_O), 32'd0);
  endtask

  // Reference model: window walk, lowest index first, and the timing
  // rules for each outcome.
  logic [31:0] base [3] = '{32'h0000_0000, 32'h0001_0000, 32'h0001_0100};
  logic [31:0] mask [3] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};

  function automatic void model(input logic [31:0] adr, input logic we, output int e_lat,
                                output logic [2:0] e_stb, output logic [31:0] e_dat,
                                output logic e_err);
    int idx;
    idx = -1;
    for (int i = 2; i >= 0; i--)
      if ((adr & mask[i]) == base[i]) idx = i;
    if (idx < 0) begin
      e_lat = 1; e_stb = 3'b000; e_err = 1'b1; e_dat = we ? 32'd0 : POISON;
    end else begin
      e_stb = 3'(1 << idx);
      if (lat[idx] < TMO) begin
        e_lat = lat[idx] + 2; e_err = 1'b0; e_dat = sdat[idx];
      end else begin
        e_lat = TMO + 1; e_err = 1'b1; e_dat = we ? 32'd0 : POISON;
      end
    end
  endfunction

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          lat;
    logic        noise;
    int          e_lat;
    logic [2:0]  e_stb;
    logic [31:0] e_dat;
    logic        e_err;
    logic [31:0] e_eadr;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_sdat;
  } vec_t;

  vec_t vt [7];

  int          r_lat;
  logic [31:0] r_dat, r_sdat, r_eadr, a, d, dat1, dat2;
  logic [2:0]  r_stb, e_stb;
  logic        r_we, r_err, e_err, w, mflag;
  logic [3:0]  r_sel, s;
  int          e_lat, first, second, acks, n;
  logic [31:0] e_dat, madr;

  initial begin
    vt[0] = '{32'h0000_0010, 32'h0, 4'hF, 1'b0, 1,   1'b0, 3, 3'b001, 32'h1234_5678, 1'b0, 32'h0,
              1'b0, 4'hF, 32'h0};
    vt[1] = '{32'h0001_0004, 32'hA5, 4'h1, 1'b1, 0,  1'b0, 2, 3'b010, 32'h0000_00C3, 1'b0, 32'h0,
              1'b1, 4'h1, 32'hA5};
    vt[2] = '{32'h8000_0000, 32'h0, 4'hF, 1'b0, 0,   1'b0, 1, 3'b000, 32'hDEAD_BEEF, 1'b1, 32'h8000_0000,
              1'b0, 4'h0, 32'h0};
    vt[3] = '{32'h0001_0100, 32'h0, 4'hF, 1'b0, 255, 1'b1, 9, 3'b100, 32'hDEAD_BEEF, 1'b1, 32'h8000_0000,
              1'b0, 4'hF, 32'h0};
    vt[4] = '{32'h0001_01FC, 32'h1122_3344, 4'hC, 1'b1, 7, 1'b1, 9, 3'b100, 32'hCAFE_F00D, 1'b1,
              32'h8000_0000, 1'b1, 4'hC, 32'h1122_3344};
    vt[5] = '{32'h0002_0000, 32'h5, 4'hF, 1'b1, 0,   1'b0, 1, 3'b000, 32'h0, 1'b1, 32'h8000_0000,
              1'b0, 4'h0, 32'h0};
    vt[6] = '{32'h0000_FFFC, 32'h0, 4'hF, 1'b0, 8,   1'b0, 9, 3'b001, 32'hDEAD_BEEF, 1'b1, 32'h8000_0000,
              1'b0, 4'hF, 32'h0};

    // Reset state
    repeat (2) @(negedge CLK_I);
    check("rst_ack", 32'(ACK_O), 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check("rst_stb", 32'(S_STB_O), 32'd0);
    check("rst_err", 32'(ERR_O), 32'd0);
    check("rst_sadr", S_ADR_O, 32'd0);
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      lat = '{vt[i].lat, vt[i].lat, vt[i].lat};
      noise = vt[i].noise;
      xfer(vt[i].adr, vt[i].dat, vt[i].sel, vt[i].we, r_lat, r_dat, r_stb, r_we, r_sel, r_sdat,
           r_err, r_eadr);
      check($sformatf("vec%0d_lat", i), 32'(r_lat), 32'(vt[i].e_lat));
      check($sformatf("vec%0d_stb", i), 32'(r_stb), 32'(vt[i].e_stb));
      check($sformatf("vec%0d_dat", i), r_dat, vt[i].e_dat);
      check($sformatf("vec%0d_err", i), 32'(r_err), 32'(vt[i].e_err));
      check($sformatf("vec%0d_eadr", i), r_eadr, vt[i].e_eadr);
      if (vt[i].e_stb != 3'b000) begin
        check($sformatf("vec%0d_we", i), 32'(r_we), 32'(vt[i].e_we));
        check($sformatf("vec%0d_sel", i), 32'(r_sel), 32'(vt[i].e_sel));
        check($sformatf("vec%0d_sdat", i), r_sdat, vt[i].e_sdat);
      end
    end
    noise = 1'b0;

    // Clear pulse: the flag drops and the captured address stays.
    @(negedge CLK_I); ERR_CLR_I = 1'b1;
    @(negedge CLK_I); ERR_CLR_I = 1'b0;
    check("clr_err", 32'(ERR_O), 32'd0);
    check("clr_eadr_kept", ERR_ADR_O, 32'h8000_0000);

    // With the flag clear, a timeout captures its own address.
    lat = '{255, 255, 255};
    xfer(32'h0001_0180, 32'h0, 4'hF, 1'b0, r_lat, r_dat, r_stb, r_we, r_sel, r_sdat, r_err, r_eadr);
    check("tmo2_lat", 32'(r_lat), 32'(TMO + 1));
    check("tmo2_dat", r_dat, POISON);
    check("tmo2_err", 32'(r_err), 32'd1);
    check("tmo2_eadr", r_eadr, 32'h0001_0180);

    // A new error in the same cycle as a clear: the set wins.
    @(negedge CLK_I); ERR_CLR_I = 1'b1;
    @(negedge CLK_I);
    check("setwin_pre", 32'(ERR_O), 32'd0);
    xfer(32'h9000_0000, 32'h0, 4'hF, 1'b0, r_lat, r_dat, r_stb, r_we, r_sel, r_sdat, r_err, r_eadr);
    ERR_CLR_I = 1'b0;
    check("setwin_err", 32'(r_err), 32'd1);
    check("setwin_eadr", r_eadr, 32'h9000_0000);

    // Master abandons the cycle while the decoder is ACTIVE.
    lat = '{255, 255, 255};
    @(negedge CLK_I);
    ADR_I = 32'h0000_0010; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    check("cycdrop_stb_before", 32'(S_STB_O), 32'b001);
    CYC_I = 1'b0; STB_I = 1'b0;
    @(negedge CLK_I);
    check("cycdrop_stb_after", 32'(S_STB_O), 32'd0);
    acks = 0;
    repeat (TMO + 2) begin
      @(negedge CLK_I);
      acks += int'(ACK_O);
    end
    check("cycdrop_no_ack", 32'(acks), 32'd0);
    lat = '{0, 0, 0};
    xfer(32'h0000_0020, 32'h0, 4'hF, 1'b0, r_lat, r_dat, r_stb, r_we, r_sel, r_sdat, r_err, r_eadr);
    check("cycdrop_next_lat", 32'(r_lat), 32'd2);
    check("cycdrop_next_dat", r_dat, sdat[0]);

    // Back-to-back reads with CYC_I held high across the ACK.
    lat = '{0, 0, 0};
    @(negedge CLK_I);
    ADR_I = 32'h0000_0040; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
    first = -1; second = -1; acks = 0; n = 0; dat1 = '0; dat2 = '0;
    while (n < 20 && second < 0) begin
      @(negedge CLK_I);
      n++;
      if (first >= 0 && n == first + 1) begin
        check("b2b_gap_stb", 32'(S_STB_O), 32'd0);
        check("b2b_gap_ack", 32'(ACK_O), 32'd0);
      end
      if (ACK_O) begin
        acks++;
        if (first < 0) begin
          first = n; dat1 = DAT_O; ADR_I = 32'h0001_0008;
        end else begin
          second = n; dat2 = DAT_O;
        end
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0;
    check("b2b_first_lat", 32'(first), 32'd2);
    check("b2b_second_lat", 32'(second), 32'd6);
    check("b2b_acks", 32'(acks), 32'd2);
    check("b2b_dat0", dat1, sdat[0]);
    check("b2b_dat1", dat2, sdat[1]);
    repeat (2) @(negedge CLK_I);

    // Reset while ACTIVE: abandon with no ACK, everything back to zero.
    lat = '{255, 255, 255};
    @(negedge CLK_I);
    ADR_I = 32'h0000_0010; CYC_I = 1'b1; STB_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    check("rstmid_stb_before", 32'(S_STB_O), 32'b001);
    RST_I = 1'b0;
    #1;
    check("rstmid_stb", 32'(S_STB_O), 32'd0);
    check("rstmid_ack", 32'(ACK_O), 32'd0);
    check("rstmid_err", 32'(ERR_O), 32'd0);
    check("rstmid_eadr", ERR_ADR_O, 32'd0);
    check("rstmid_sadr", S_ADR_O, 32'd0);
    CYC_I = 1'b0; STB_I = 1'b0;
    @(negedge CLK_I); RST_I = 1'b1;
    lat = '{0, 0, 0};
    xfer(32'h0000_0020, 32'h0, 4'hF, 1'b0, r_lat, r_dat, r_stb, r_we, r_sel, r_sdat, r_err, r_eadr);
    check("rstmid_next_lat", 32'(r_lat), 32'd2);
    check("rstmid_next_dat", r_dat, sdat[0]);
    mflag = 1'b0;
    madr = '0;

    // Randomized traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0: a = {16'h0000, 16'($urandom)};
        1: a = 32'h0001_0000 | 32'($urandom_range(0, 255));
        2: a = 32'h0001_0100 | 32'($urandom_range(0, 255));
        3: a = 32'($urandom) | 32'h8000_0000;
        4: a = 32'h0001_0200 + 32'($urandom_range(0, 32'hFFFF));
        default: a = ($urandom_range(0, 1) == 0) ? 32'h0001_00FF : 32'h0001_01FF;
      endcase
      d = 32'($urandom);
      s = 4'($urandom_range(1, 15));
      w = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        lat[i] = $urandom_range(0, 10);
        if (lat[i] == 10) lat[i] = 255;
        sdat[i] = 32'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        @(negedge CLK_I); ERR_CLR_I = 1'b1;
        @(negedge CLK_I); ERR_CLR_I = 1'b0;
        mflag = 1'b0;
      end
      model(a, w, e_lat, e_stb, e_dat, e_err);
      if (e_err) begin
        if (!mflag) madr = a;
        mflag = 1'b1;
      end
      xfer(a, d, s, w, r_lat, r_dat, r_stb, r_we, r_sel, r_sdat, r_err, r_eadr);
      check($sformatf("rnd%0d_lat", t), 32'(r_lat), 32'(e_lat));
      check($sformatf("rnd%0d_stb", t), 32'(r_stb), 32'(e_stb));
      check($sformatf("rnd%0d_dat", t), r_dat, e_dat);
      check($sformatf("rnd%0d_err", t), 32'(r_err), 32'(mflag));
      check($sformatf("rnd%0d_eadr", t), r_eadr, madr);
      if (e_stb != 3'b000) begin
        check($sformatf("rnd%0d_we", t), 32'(r_we), 32'(w));
        check($sformatf("rnd%0d_sel", t), 32'(r_sel), 32'(s));
        check($sformatf("rnd%0d_sdat", t), r_sdat, d);
      end
    end
    noise = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_addr_decoder.md
Name: wb_addr_decoder

Overview:
- Wishbone B4 classic single-master interconnect directly downstream of the CPU bus master.
- Consumes the master's CYC/STB/ADR/DAT/SEL/WE and decodes the address to one of three slaves: RAM, UART, timer.
- Forwards the cycle to the selected slave and returns a registered ACK and read data.
- Unmapped accesses and slave timeouts terminate with a normal ACK, poison data and a sticky error flag.

Parameters:
- S0_BASE, 32'h0000_0000, slave 0 (RAM) base address
- S0_MASK, 32'hFFFF_0000, slave 0 address compare mask
- S1_BASE, 32'h0001_0000, slave 1 (UART) base address
- S1_MASK, 32'hFFFF_FF00, slave 1 compare mask
- S2_BASE, 32'h0001_0100, slave 2 (timer) base address
- S2_MASK, 32'hFFFF_FF00, slave 2 compare mask
- TIMEOUT, 255, maximum cycles to wait for a slave ACK (1..255)
- POISON, 32'hDEADBEEF, read data returned on an error termination

Ports:
- CLK_I  in  1  clock, rising edge
- RST_I  in  1  reset, asynchronous assert, active-low
- ADR_I  in  32  master address
- DAT_I  in  32  master write data
- SEL_I  in  4  master byte select
- WE_I  in  1  master write enable
- CYC_I  in  1  master cycle
- STB_I  in  1  master strobe
- DAT_O  out  32  read data to master
- ACK_O  out  1  termination to master
- ERR_O  out  1  sticky error flag
- ERR_ADR_O  out  32  address of the first faulting access
- ERR_CLR_I  in  1  clears ERR_O for one cycle pulse
- S_ADR_O  out  32  shared slave address
- S_DAT_O  out  32  shared slave write data
- S_SEL_O  out  4  shared slave byte select
- S_WE_O  out  1  shared slave write enable
- S_CYC_O  out  3  per-slave cycle, one-hot
- S_STB_O  out  3  per-slave strobe, one-hot
- S_ACK_I  in  3  per-slave acknowledge
- S_DAT_I  in  96  slave read data; slave n drives bits [32n+31:32n]

Behaviour:
- Reset (RST_I=0): all outputs 0 immediately; state IDLE; timeout counter 0. Reset mid-transaction abandons the transaction with no ACK.
- Address decode: slave n matches when (ADR_I & Sn_MASK) == Sn_BASE. If several match, the lowest index wins.
- IDLE:
  - On CYC_I&STB_I, register ADR/DAT/SEL/WE onto the S_* buses.
  - On a match: set S_CYC_O/S_STB_O bit n, clear the counter, go to ACTIVE.
  - On no match: go to RESP with error.
- ACTIVE:
  - When S_ACK_I[n] is high: latch S_DAT_I slice n into DAT_O, drop S_CYC_O/S_STB_O, go to RESP (ok).
  - Otherwise increment the counter. When the counter reaches TIMEOUT, drop the slave strobes and go to RESP (error).
  - ACK from a non-selected slave is ignored.
  - If CYC_I falls, drop the slave strobes and return to IDLE with no ACK.
- RESP: ACK_O=1 for exactly one cycle, then go to IDLE.
  - Ok path: DAT_O holds the slave data.
  - Error path: DAT_O=POISON for reads and 0 for writes.
  - ACK_O is never asserted outside RESP.
- The master drops CYC on the edge after ACK. IDLE therefore ignores CYC_I in the cycle immediately following RESP, which guarantees one idle cycle between transactions.
- Latency: request sampled at edge 0; S_STB_O high in cycle 1; a slave with combinational ACK gives ACK_O in cycle 2. Minimum 2 cycles; the unmapped path is 1 cycle.
- Error flag:
  - On error entry, ERR_O is set to 1. ERR_ADR_O captures ADR_I only if ERR_O was 0.
  - ERR_CLR_I clears ERR_O.
  - If a new error and ERR_CLR_I occur in the same cycle, the set wins.
- S_ADR_O/S_DAT_O/S_SEL_O/S_WE_O hold their values outside transactions. S_WE_O clears when the strobes drop.

Test Plan:
- Read 0x0000_0010, slave 0 ACKs one cycle after strobe with 0x1234_5678 -> S_STB_O=3'b001; ACK_O one cycle after S_ACK_I; DAT_O=0x1234_5678; ERR_O=0.
- Write 0x0001_0004, SEL=4'b0001, DAT=0xA5 -> S_STB_O=3'b010, S_WE_O=1, S_SEL_O=0001, S_DAT_O=0xA5; ACK_O once; S_WE_O back to 0.
- Read 0x8000_0000 (unmapped) -> no S_STB_O; ACK_O 1 cycle after request; DAT_O=0xDEADBEEF; ERR_O=1; ERR_ADR_O=0x8000_0000.
- Slave 2 never ACKs, TIMEOUT=8 -> strobe held 8 cycles then dropped; ACK_O with POISON; ERR_O=1. Then pulse ERR_CLR_I -> ERR_O=0.
- Master drops CYC_I in ACTIVE, and separately RST_I=0 in ACTIVE -> strobes drop; no ACK_O; next request 0x0000_0020 completes normally.
- Back-to-back reads to slaves 0 and 1 -> exactly one ACK_O per request, at least one idle cycle between them, no cross-slave strobe overlap.
